fc_loss: RTL and testbench

//  Loss/argmax stage directly downstream of the fully-connected layer. Collects the
//  NUM_CLASSES ReLU'd Q16.16 scores of one sample, tracks the running argmax, and

---
 rtl/cnn_pkg.sv | 24 ++
 rtl/fc_loss_argmax.sv | 44 ++++
 rtl/fc_loss.sv | 140 ++++++++++++++
 tb/tb_fc_loss.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: Q16.16 scalar, constant 1.0, saturating subtract
// and the fc_loss state encoding.
package cnn_pkg;

    typedef logic signed [31:0] q16_t;

    localparam q16_t Q_ONE = 32'sh0001_0000;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } fc_loss_state_e;

    // 33-bit difference, clamped back into the Q16.16 range
    function automatic q16_t sat_sub(input q16_t a, input q16_t b);
        logic signed [32:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[32] != d[31])
            sat_sub = d[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else
            sat_sub = d[31:0];
    endfunction

endpackage

// File: rtl/fc_loss_argmax.sv
// Running signed max/argmax tracker; idx 0 restarts the search.
// Ties keep the lower index because only a strictly greater score wins.
module fc_loss_argmax
    import cnn_pkg::*;
#(
    parameter int IDX_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IDX_WIDTH-1:0] idx,
    input  q16_t                 data,
    output logic [IDX_WIDTH-1:0] arg_nxt
);

    q16_t                 max_q;
    q16_t                 max_nxt;
    logic [IDX_WIDTH-1:0] arg_q;

    always_comb begin
        max_nxt = max_q;
        arg_nxt = arg_q;
        if (en) begin
            if (idx == '0) begin
                max_nxt = data;
                arg_nxt = '0;
            end else if (data > max_q) begin
                max_nxt = data;
                arg_nxt = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_nxt;
            arg_q <= arg_nxt;
        end
    end

endmodule

// File: rtl/fc_loss.sv
// Loss/argmax stage after the fc layer: streams score-minus-onehot errors back.
// Optional FC_LOSS_ACC_EN adds saturating sample/hit counters.
module fc_loss
    import cnn_pkg::*;
#(
    parameter int          NUM_CLASSES = 10,
    parameter int          IDX_WIDTH   = 10,
    parameter logic [31:0] ONE         = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    input  logic [IDX_WIDTH-1:0] in_idx,
    input  logic [IDX_WIDTH-1:0] label,
    output logic                 in_rdy,
    output logic                 out_valid,
    input  logic                 out_rdy,
    output logic [31:0]          out_data,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic [IDX_WIDTH-1:0] pred_class,
    output logic                 pred_valid,
    output logic                 correct,
    output logic [15:0]          hit_count,
    output logic [15:0]          sample_cnt
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH:0]   NCLS = (IDX_WIDTH + 1)'(NUM_CLASSES);

    fc_loss_state_e       state;
    fc_loss_state_e       state_nxt;
    q16_t                 scores [NUM_CLASSES];
    logic [IDX_WIDTH-1:0] label_q;
    logic [IDX_WIDTH-1:0] label_eff;
    logic [IDX_WIDTH-1:0] arg_nxt;
    logic [IDX_WIDTH-1:0] emit_idx;
    logic [IDX_WIDTH-1:0] emit_label;
    logic                 accept;
    logic                 last_acc;
    logic                 hs;
    logic                 hs_last;
    q16_t                 emit_score;
    q16_t                 err_nxt;

    assign in_rdy    = (state == COLLECT);
    assign out_valid = (state == EMIT);
    assign accept    = in_valid & in_rdy & ({1'b0, in_idx} < NCLS);
    assign last_acc  = accept & (in_idx == LAST);
    assign hs        = out_valid & out_rdy;
    assign hs_last   = hs & (out_idx == LAST);
    assign label_eff = (in_idx == '0) ? label : label_q;

    fc_loss_argmax #(
        .IDX_WIDTH (IDX_WIDTH)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .idx     (in_idx),
        .data    (in_data),
        .arg_nxt (arg_nxt)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: if (last_acc) state_nxt = EMIT;
            EMIT:    if (hs_last)  state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Index 0 bypasses the store so a single-class sample works
    always_comb begin
        emit_idx   = (state == COLLECT) ? '0 : out_idx + 1'b1;
        emit_label = (state == COLLECT) ? label_eff : label_q;
        emit_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++)
            if (emit_idx == IDX_WIDTH'(k))
                emit_score = scores[k];
        if (state == COLLECT && in_idx == '0)
            emit_score = in_data;
        err_nxt = sat_sub(emit_score,
                          (emit_idx == emit_label) ? q16_t'(ONE) : '0);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CLASSES; k++)
            if (accept && in_idx == IDX_WIDTH'(k))
                scores[k] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            label_q    <= '0;
            pred_class <= '0;
            pred_valid <= 1'b0;
            correct    <= 1'b0;
            out_idx    <= '0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            pred_valid <= last_acc;
            if (accept && in_idx == '0)
                label_q <= label;
            if (last_acc) begin
                pred_class <= arg_nxt;
                correct    <= (arg_nxt == label_eff);
                out_idx    <= '0;
                out_data   <= err_nxt;
            end else if (hs_last) begin
                out_idx  <= '0;
                out_data <= '0;
            end else if (hs) begin
                out_idx  <= out_idx + 1'b1;
                out_data <= err_nxt;
            end
        end
    end

`ifdef FC_LOSS_ACC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            hit_count  <= '0;
        end else if (pred_valid) begin
            if (sample_cnt != 16'hFFFF)
                sample_cnt <= sample_cnt + 16'd1;
            if (correct && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
        end
    end
`else
    assign sample_cnt = '0;
    assign hit_count  = '0;
`endif

endmodule

// File: tb/tb_fc_loss.sv
// Directed, table-driven bench for fc_loss (NUM_CLASSES=10).
module tb_fc_loss;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [9:0]  in_idx;
    logic [9:0]  label;
    logic        in_rdy;
    logic        out_valid;
    logic        out_rdy;
    logic [31:0] out_data;
    logic [9:0]  out_idx;
    logic [9:0]  pred_class;
    logic        pred_valid;
    logic        correct;
    logic [15:0] hit_count;
    logic [15:0] sample_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] sc  [10];
        logic [9:0]  lbl;
        logic [9:0]  pred;
        logic        corr;
        logic [31:0] err [10];
    } vec_t;

    vec_t vt [5];

    fc_loss dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_idx     (in_idx),
        .label      (label),
        .in_rdy     (in_rdy),
        .out_valid  (out_valid),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .pred_class (pred_class),
        .pred_valid (pred_valid),
        .correct    (correct),
        .hit_count  (hit_count),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_scores(input int v, input bit drop);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_idx   = 10'(k);
            in_data  = vt[v].sc[k];
            label    = (k == 0) ? vt[v].lbl : 10'h3FF;
            @(posedge clk); #1;
            if (drop && k == 2) begin
                in_idx  = 10'd12;
                in_data = 32'h7FFF_FFFF;
                label   = 10'd12;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input int v, input logic [3:0] pat,
                           input bit drop);
        int beat;
        int c;
        chk("in_rdy_idle", 32'(in_rdy), 32'd1);
        send_scores(v, drop);
        chk("pred_valid", 32'(pred_valid), 32'd1);
        chk("pred_class", 32'(pred_class), 32'(vt[v].pred));
        chk("correct", 32'(correct), 32'(vt[v].corr));
        chk("in_rdy_emit", 32'(in_rdy), 32'd0);
        beat = 0;
        c = 0;
        while (beat < 10 && c < 60) begin
            out_rdy = pat[c % 4];
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_idx", 32'(out_idx), 32'(beat));
            chk("out_data", out_data, vt[v].err[beat]);
            if (c == 1)
                chk("pred_pulse", 32'(pred_valid), 32'd0);
            @(posedge clk); #1;
            if (out_rdy)
                beat++;
            c++;
        end
        out_rdy = 1'b0;
        chk("beats_done", 32'(beat), 32'd10);
        chk("in_rdy_back", 32'(in_rdy), 32'd1);
        chk("out_valid_off", 32'(out_valid), 32'd0);
        chk("correct_held", 32'(correct), 32'(vt[v].corr));
    endtask

    initial begin
        int c;
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 10; k++) begin
                vt[v].sc[k]  = 32'h0;
                vt[v].err[k] = 32'h0;
            end
        end
        vt[0].sc[0] = 32'h0001_0000;
        vt[0].sc[1] = 32'h0003_0000;
        vt[0].sc[2] = 32'h0002_0000;
        vt[0].lbl = 10'd1; vt[0].pred = 10'd1; vt[0].corr = 1'b1;
        vt[0].err[0] = 32'h0001_0000;
        vt[0].err[1] = 32'h0002_0000;
        vt[0].err[2] = 32'h0002_0000;
        for (int k = 0; k < 10; k++) begin
            vt[1].sc[k]  = 32'h0000_8000;
            vt[1].err[k] = 32'h0000_8000;
        end
        vt[1].err[4] = 32'hFFFF_8000;
        vt[1].lbl = 10'd4; vt[1].pred = 10'd0; vt[1].corr = 1'b0;
        vt[2].sc[2]  = 32'h8000_0000;
        vt[2].err[2] = 32'h8000_0000;
        vt[2].lbl = 10'd2; vt[2].pred = 10'd0; vt[2].corr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            vt[3].sc[k]  = 32'h0001_0000;
            vt[3].err[k] = 32'h0001_0000;
            vt[4].sc[k]  = 32'(k) << 16;
            vt[4].err[k] = 32'(k) << 16;
        end
        vt[3].sc[9]  = 32'h0005_0000;
        vt[3].err[9] = 32'h0004_0000;
        vt[3].lbl = 10'd9; vt[3].pred = 10'd9; vt[3].corr = 1'b1;
        vt[4].lbl = 10'd11; vt[4].pred = 10'd9; vt[4].corr = 1'b0;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_idx = '0;
        label = '0;
        out_rdy = 1'b0;
        #12;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_pred_class", 32'(pred_class), 32'd0);
        chk("rst_pred_valid", 32'(pred_valid), 32'd0);
        chk("rst_correct", 32'(correct), 32'd0);
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_vec(0, 4'b1111, 1'b0);
        run_vec(1, 4'b1001, 1'b0);
        run_vec(2, 4'b1111, 1'b1);
        run_vec(3, 4'b0110, 1'b0);
        run_vec(4, 4'b1111, 1'b0);

        // abort the stream at beat 5 with an async reset
        send_scores(3, 1'b0);
        out_rdy = 1'b1;
        c = 0;
        while (out_idx != 10'd5 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        chk("reach_idx5", 32'(out_idx), 32'd5);
        out_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_rdy", 32'(in_rdy), 32'd1);
        chk("arst_out_idx", 32'(out_idx), 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_vec(0, 4'b1111, 1'b0);
        run_vec(1, 4'b1111, 1'b0);
        run_vec(3, 4'b1111, 1'b0);
`ifdef FC_LOSS_ACC_EN
        chk("sample_cnt", 32'(sample_cnt), 32'd3);
        chk("hit_count", 32'(hit_count), 32'd2);
`else
        chk("sample_cnt_off", 32'(sample_cnt), 32'd0);
        chk("hit_count_off", 32'(hit_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
